// File: rtl/dac_channel_scheduler.sv
// Two-channel round-robin scheduler feeding a single SPI DAC writer.
// One-deep holding register per channel, newest sample wins, saturating overrun counters.
module dac_channel_scheduler #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ch0_valid_i,
  input  logic [DATA_W-1:0] ch0_data_i,
  input  logic              ch1_valid_i,
  input  logic [DATA_W-1:0] ch1_data_i,
  input  logic [1:0]        enable_i,
  input  logic              dac_busy_i,
  output logic              dac_start_o,
  output logic [DATA_W-1:0] dac_data_o,
  output logic              dac_chan_o,
  output logic [1:0]        pending_o,
  output logic [CNT_W-1:0]  overrun0_o,
  output logic [CNT_W-1:0]  overrun1_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  state_t                   state_r, state_nxt_s;
  logic [1:0][DATA_W-1:0]   hold_r;
  logic [1:0][CNT_W-1:0]    ovr_r;
  logic [1:0][DATA_W-1:0]   in_data_s;
  logic [1:0]               pending_r;
  logic [1:0]               load_s;
  logic [1:0]               elig_s;
  logic [1:0]               grant_vec_s;
  logic                     grant_en_s;
  logic                     grant_ch_s;
  logic                     last_r;
  logic                     dac_start_r;
  logic [DATA_W-1:0]        dac_data_r;
  logic                     dac_chan_r;

  assign in_data_s[0] = ch0_data_i;
  assign in_data_s[1] = ch1_data_i;
  assign load_s       = {ch1_valid_i, ch0_valid_i} & enable_i;
  assign elig_s       = pending_r & enable_i;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode; busy is ignored in START and GUARD
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = grant_en_s ? ST_START : ST_IDLE;
      ST_START: state_nxt_s = ST_GUARD;
      ST_GUARD: state_nxt_s = ST_WAIT;
      ST_WAIT:  state_nxt_s = dac_busy_i ? ST_WAIT : ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: grant selection, alternating on ties
  always_comb begin
    grant_en_s  = 1'b0;
    grant_ch_s  = 1'b0;
    grant_vec_s = 2'b00;
    if ((state_r == ST_IDLE) && (elig_s != 2'b00)) begin
      grant_en_s = 1'b1;
      if (elig_s == 2'b11) begin
        grant_ch_s = ~last_r;
      end else begin
        grant_ch_s = elig_s[1];
      end
      grant_vec_s = grant_ch_s ? 2'b10 : 2'b01;
    end else begin
      grant_en_s = 1'b0;
    end
  end

  // Transfer outputs, captured at grant and held until the next grant
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dac_start_r <= 1'b0;
      dac_data_r  <= {DATA_W{1'b0}};
      dac_chan_r  <= 1'b0;
      last_r      <= 1'b1;
    end else begin
      dac_start_r <= (state_nxt_s == ST_START);
      if (grant_en_s) begin
        dac_data_r <= hold_r[grant_ch_s];
        dac_chan_r <= grant_ch_s;
        last_r     <= grant_ch_s;
      end else begin
        dac_data_r <= dac_data_r;
        dac_chan_r <= dac_chan_r;
        last_r     <= last_r;
      end
    end
  end

  // Per-channel holding registers, pending flags and overrun counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_r    <= '0;
      pending_r <= 2'b00;
      ovr_r     <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (!enable_i[n]) begin
          pending_r[n] <= 1'b0;
        end else if (load_s[n]) begin
          hold_r[n]    <= in_data_s[n];
          pending_r[n] <= 1'b1;
          if (pending_r[n] && !grant_vec_s[n]) begin
            ovr_r[n] <= sat_inc(ovr_r[n]);
          end
        end else if (grant_vec_s[n]) begin
          pending_r[n] <= 1'b0;
        end
      end
    end
  end

  assign dac_start_o = dac_start_r;
  assign dac_data_o  = dac_data_r;
  assign dac_chan_o  = dac_chan_r;
  assign pending_o   = pending_r;
  assign overrun0_o  = ovr_r[0];
  assign overrun1_o  = ovr_r[1];

endmodule
